// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential C = A x B using ROWS_A*COLS_B MAC units, one inner index per cycle
// Ports: clk/rst_n (async active-low), abort (sync return to IDLE);
//   in_valid/in_ready + A, B, is_signed: operand handshake, accepted only in IDLE;
//   out_valid/out_ready + C, ovf: result handshake, held stable until accepted.
module matrix_mult_seq #(
  parameter int DSIZE = 8,
  parameter int ROWS_A = 4,
  parameter int INNER = 4,
  parameter int COLS_B = 4,
  parameter int OSIZE = 16,
  parameter int SAT = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             abort,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             is_signed,
  input  logic [ROWS_A*INNER*DSIZE-1:0]    A,
  input  logic [INNER*COLS_B*DSIZE-1:0]    B,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ROWS_A*COLS_B*OSIZE-1:0]   C,
  output logic                             ovf
);
  localparam int ACC = 2*DSIZE + $clog2(INNER) + 1;
  localparam int NE = ROWS_A*COLS_B;
  localparam int KW = INNER > 1 ? $clog2(INNER) : 1;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [ROWS_A*INNER*DSIZE-1:0] a_q, a_d;
  logic [INNER*COLS_B*DSIZE-1:0] b_q, b_d;
  logic sgn_q, sgn_d;
  logic [ACC-1:0] acc_q [NE];
  logic [ACC-1:0] acc_d [NE];
  logic [ACC-1:0] sum [NE];
  logic [NE*OSIZE-1:0] c_q, c_d, nar;
  logic [NE-1:0] clip;
  logic ovf_q, ovf_d, out_valid_q, out_valid_d;
  for (genvar m = 0; m < ROWS_A; m++) begin : g_r
    for (genvar n = 0; n < COLS_B; n++) begin : g_c
      localparam int I = m*COLS_B + n;
      logic [DSIZE-1:0] av, bv;
      logic [ACC-1:0] ea, eb, s, sh;
      logic fit;
      assign av = a_q[(m*INNER + int'(k_q))*DSIZE +: DSIZE];
      assign bv = b_q[(int'(k_q)*COLS_B + n)*DSIZE +: DSIZE];
      assign ea = sgn_q ? {{(ACC-DSIZE){av[DSIZE-1]}}, av} : {{(ACC-DSIZE){1'b0}}, av};
      assign eb = sgn_q ? {{(ACC-DSIZE){bv[DSIZE-1]}}, bv} : {{(ACC-DSIZE){1'b0}}, bv};
      assign s = acc_q[I] + ea*eb;
      // Shifts instead of slices so OSIZE == ACC needs no special case.
      assign sh = $signed(s) >>> (OSIZE-1);
      assign fit = sgn_q ? (sh == '0 || sh == '1) : (s >> OSIZE) == '0;
      assign sum[I] = s;
      assign nar[I*OSIZE +: OSIZE] = (SAT == 0 || fit) ? s[OSIZE-1:0] :
                                     !sgn_q ? '1 :
                                     s[ACC-1] ? {1'b1, {(OSIZE-1){1'b0}}} : {1'b0, {(OSIZE-1){1'b1}}};
      assign clip[I] = !fit;
    end
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    a_d = a_q;
    b_d = b_q;
    sgn_d = sgn_q;
    acc_d = acc_q;
    c_d = c_q;
    ovf_d = ovf_q;
    out_valid_d = out_valid_q;
    if (abort) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      k_d = '0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        state_d = COMPUTE;
        a_d = A;
        b_d = B;
        sgn_d = is_signed;
        acc_d = '{default: '0};
        k_d = '0;
      end
    end else if (state_q == COMPUTE) begin
      acc_d = sum;
      k_d = k_q + KW'(1);
      if (k_q == KW'(INNER-1)) begin
        state_d = DONE;
        k_d = '0;
        c_d = nar;
        ovf_d = |clip;
        out_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sgn_q <= 1'b0;
      acc_q <= '{default: '0};
      c_q <= '0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      a_q <= a_d;
      b_q <= b_d;
      sgn_q <= sgn_d;
      acc_q <= acc_d;
      c_q <= c_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign C = c_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb_matrix_mult_seq: directed bench for matrix_mult_seq (saturate, wrap and small-parameter instances)
module tb_matrix_mult_seq;
  logic clk = 0, rst_n = 0, abort = 0, in_valid = 0, is_signed = 0, out_ready = 1;
  logic [127:0] a, b, a_id, b_seq;
  logic [255:0] c0, c1, c_seq;
  logic in_ready0, in_ready1, ov0, ov1, ovf0, ovf1;
  logic in_valid2 = 0, sgn2 = 0, out_ready2 = 1, in_ready2, ov2, ovf2;
  logic [23:0] a2;
  logic [59:0] b2;
  logic [99:0] c2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  matrix_mult_seq #(.SAT(1)) u0 (.clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready0),
    .is_signed(is_signed), .A(a), .B(b), .out_valid(ov0), .out_ready(out_ready), .C(c0), .ovf(ovf0));
  matrix_mult_seq #(.SAT(0)) u1 (.clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready1),
    .is_signed(is_signed), .A(a), .B(b), .out_valid(ov1), .out_ready(out_ready), .C(c1), .ovf(ovf1));
  matrix_mult_seq #(.DSIZE(4), .ROWS_A(2), .INNER(3), .COLS_B(5), .OSIZE(10), .SAT(1)) u2 (.clk(clk), .rst_n(rst_n),
    .abort(abort), .in_valid(in_valid2), .in_ready(in_ready2), .is_signed(sgn2), .A(a2), .B(b2), .out_valid(ov2),
    .out_ready(out_ready2), .C(c2), .ovf(ovf2));
  task automatic go(input logic [127:0] av, input logic [127:0] bv, input logic s);
    a = av;
    b = bv;
    is_signed = s;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic wait_valid(input int which, output int n);
    n = 0;
    while (!(which == 0 ? ov0 : ov2) && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
  endtask
  function automatic logic [99:0] model(input logic [23:0] av, input logic [59:0] bv, input logic s, output logic o);
    logic [99:0] r = '0;
    o = 0;
    for (int m = 0; m < 2; m++)
      for (int n = 0; n < 5; n++) begin
        int acc = 0;
        int lo = s ? -512 : 0;
        int hi = s ? 511 : 1023;
        int v;
        for (int k = 0; k < 3; k++) begin
          logic [3:0] x = av[(m*3+k)*4 +: 4];
          logic [3:0] y = bv[(k*5+n)*4 +: 4];
          acc += (s ? int'($signed(x)) : int'(x)) * (s ? int'($signed(y)) : int'(y));
        end
        v = acc < lo ? lo : acc > hi ? hi : acc;
        o |= (acc < lo || acc > hi);
        r[(m*5+n)*10 +: 10] = v[9:0];
      end
    return r;
  endfunction
  task automatic test_reset;
    #12;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready0); end
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov0); end
    checks++; if (c0 !== '0) begin failures++; $display("FAIL reset_c got=%h exp=0", c0); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf0); end
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_identity;
    int n;
    go(a_id, b_seq, 0);
    checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL id_accept got=%b exp=0", in_ready0); end
    wait_valid(0, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL id_latency got=%0d exp=4", n); end
    checks++; if (c0 !== c_seq) begin failures++; $display("FAIL id_c got=%h exp=%h", c0, c_seq); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL id_ovf got=%b exp=0", ovf0); end
    @(posedge clk);
    #1;
    checks++; if ({in_ready0, ov0} !== 2'b10) begin failures++; $display("FAIL id_return got=%b exp=10", {in_ready0, ov0}); end
  endtask
  task automatic test_signed;
    int n;
    go({16{8'h80}}, {16{8'h7F}}, 1);
    wait_valid(0, n);
    checks++; if (c0 !== {16{16'h8000}}) begin failures++; $display("FAIL sgn_sat_c got=%h exp=8000..", c0); end
    checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL sgn_sat_ovf got=%b exp=1", ovf0); end
    checks++; if (c1 !== {16{16'h0200}}) begin failures++; $display("FAIL sgn_wrap_c got=%h exp=0200..", c1); end
    checks++; if (ovf1 !== 1'b1) begin failures++; $display("FAIL sgn_wrap_ovf got=%b exp=1", ovf1); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_unsigned_max;
    int n;
    go({16{8'hFF}}, {16{8'hFF}}, 0);
    wait_valid(0, n);
    checks++; if (c1 !== {16{16'hF804}}) begin failures++; $display("FAIL umax_wrap_c got=%h exp=F804..", c1); end
    checks++; if (ovf1 !== 1'b1) begin failures++; $display("FAIL umax_wrap_ovf got=%b exp=1", ovf1); end
    checks++; if (c0 !== {16{16'hFFFF}}) begin failures++; $display("FAIL umax_sat_c got=%h exp=FFFF..", c0); end
    checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL umax_sat_ovf got=%b exp=1", ovf0); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_backpressure;
    int n;
    out_ready = 0;
    go(a_id, b_seq, 0);
    a = {16{8'h01}};
    b = {16{8'h01}};
    in_valid = 1;
    wait_valid(0, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", n); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({ov0, ovf0, in_ready0, c0} !== {3'b100, c_seq}) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b%b%b %h exp=100 %h", i, ov0, ovf0, in_ready0, c0, c_seq);
      end
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    checks++; if ({in_ready0, ov0} !== 2'b10) begin failures++; $display("FAIL bp_release got=%b exp=10", {in_ready0, ov0}); end
    @(posedge clk);
    #1 in_valid = 0;
    checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL bp_next_accept got=%b exp=0", in_ready0); end
    wait_valid(0, n);
    checks++; if (c0 !== {16{16'd4}}) begin failures++; $display("FAIL bp_next_c got=%h exp=0004..", c0); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_abort;
    logic seen = 0;
    go(a_id, b_seq, 0);
    @(posedge clk);
    #1 abort = 1;
    @(posedge clk);
    #1 abort = 0;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b exp=1", in_ready0); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 seen |= ov0;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_valid got=%b exp=0", seen); end
    checks++; if (c0 !== {16{16'd4}}) begin failures++; $display("FAIL abort_keep_c got=%h exp=0004..", c0); end
    a = a_id;
    b = b_seq;
    in_valid = 1;
    abort = 1;
    @(posedge clk);
    #1 in_valid = 0;
    abort = 0;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL abort_reject got=%b exp=1", in_ready0); end
  endtask
  task automatic test_reset_mid;
    go(a_id, b_seq, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    checks++;
    if ({in_ready0, ov0, ovf0, c0} !== {3'b100, 256'd0}) begin
      failures++; $display("FAIL async_reset got=%b%b%b %h exp=100 0", in_ready0, ov0, ovf0, c0);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_sweep;
    int n;
    logic [99:0] exp_c;
    logic exp_o;
    for (int t = 0; t < 6; t++) begin
      a2 = t == 0 ? {6{4'h8}} : 24'($urandom);
      b2 = t == 0 ? {15{4'h8}} : {28'($urandom), 32'($urandom)};
      sgn2 = t == 0 ? 1'b1 : t[0];
      exp_c = model(a2, b2, sgn2, exp_o);
      in_valid2 = 1;
      @(posedge clk);
      #1 in_valid2 = 0;
      wait_valid(2, n);
      checks++; if (n !== 3) begin failures++; $display("FAIL sweep_latency t=%0d got=%0d exp=3", t, n); end
      checks++; if (c2 !== exp_c) begin failures++; $display("FAIL sweep_c t=%0d got=%h exp=%h", t, c2, exp_c); end
      checks++; if (ovf2 !== exp_o) begin failures++; $display("FAIL sweep_ovf t=%0d got=%b exp=%b", t, ovf2, exp_o); end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    a = '0;
    b = '0;
    a2 = '0;
    b2 = '0;
    a_id = '0;
    for (int i = 0; i < 16; i++) begin
      b_seq[i*8 +: 8] = 8'(i+1);
      c_seq[i*16 +: 16] = 16'(i+1);
    end
    for (int i = 0; i < 4; i++) a_id[(i*4+i)*8 +: 8] = 8'd1;
    test_reset;
    test_identity;
    test_signed;
    test_unsigned_max;
    test_backpressure;
    test_abort;
    test_reset_mid;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
